// File: rtl/sim_dsp_simd_mac_if.sv
// sim_dsp_simd_mac_if
//  Sample/result bundle for the SIMD multiply/MAC datapath.
//  master: stimulus side (drives samples, observes results)
//  slave : datapath side (accepts samples, drives results)
//  in_valid/mode_acc/signed_en/acc_clr : per-sample controls
//  a, b      : packed lane operands, lane i at [i*W +: W]
//  out_valid : z carries a sample result this cycle
//  z         : packed lane results
//  ovf       : per-lane sticky accumulate-overflow flags
`timescale 1ns/1ps
interface sim_dsp_simd_mac_if #(
   parameter int LANES   = 2,
   parameter int A_WIDTH = 10,
   parameter int B_WIDTH = 9,
   parameter int Z_WIDTH = 19
);
   logic                       in_valid;
   logic                       mode_acc;
   logic                       signed_en;
   logic                       acc_clr;
   logic [LANES*A_WIDTH-1:0]   a;
   logic [LANES*B_WIDTH-1:0]   b;
   logic                       out_valid;
   logic [LANES*Z_WIDTH-1:0]   z;
   logic [LANES-1:0]           ovf;

   modport master (
      output in_valid, mode_acc, signed_en, acc_clr, a, b,
      input  out_valid, z, ovf
   );

   modport slave (
      input  in_valid, mode_acc, signed_en, acc_clr, a, b,
      output out_valid, z, ovf
   );
endinterface

// File: rtl/sim_dsp_simd_mac.sv
// sim_dsp_simd_mac
//  N-lane SIMD multiply / multiply-accumulate datapath with PIPE-cycle
//  latency, signed/unsigned operands, per-lane accumulator and sticky
//  overflow flag.
//  clk     : clock, all state on posedge
//  reset_n : asynchronous active-low reset
//  bus     : sim_dsp_simd_mac_if.slave (samples in, results out)
`timescale 1ns/1ps

// One lane: stage-1 multiply/accumulate plus the result delay line.
module sim_dsp_simd_mac_lane #(
   parameter int A_WIDTH = 10,
   parameter int B_WIDTH = 9,
   parameter int Z_WIDTH = 19,
   parameter int PIPE    = 1
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [PIPE-1:0]    vld,        // vld[k]: stage k holds a sample (vld[0] = in_valid)
   input  logic               mode_acc,
   input  logic               signed_en,
   input  logic               acc_clr,
   input  logic [A_WIDTH-1:0] a,
   input  logic [B_WIDTH-1:0] b,
   output logic [Z_WIDTH-1:0] z,
   output logic               ovf
);
   logic [Z_WIDTH-1:0] ae, be, p, r, acc, acc_d;
   logic [Z_WIDTH:0]   sum;
   logic               ovf_d, add_ovf;
   logic [Z_WIDTH-1:0] r_pipe [1:PIPE];

   // Operands extended to full result width, so the truncated product is
   // already correct in two's complement for the signed case.
   assign ae  = signed_en ? {{(Z_WIDTH-A_WIDTH){a[A_WIDTH-1]}}, a}
                          : {{(Z_WIDTH-A_WIDTH){1'b0}}, a};
   assign be  = signed_en ? {{(Z_WIDTH-B_WIDTH){b[B_WIDTH-1]}}, b}
                          : {{(Z_WIDTH-B_WIDTH){1'b0}}, b};
   assign p   = ae * be;
   assign sum = {1'b0, acc} + {1'b0, p};

   // Unsigned: carry out. Signed: same-sign addends, result sign flipped.
   assign add_ovf = signed_en ? ((acc[Z_WIDTH-1] == p[Z_WIDTH-1]) &&
                                 (sum[Z_WIDTH-1] != acc[Z_WIDTH-1]))
                              : sum[Z_WIDTH];

   always_comb begin
      r     = p;
      acc_d = acc;
      ovf_d = ovf;
      if (vld[0] && mode_acc && !acc_clr) begin
         r     = sum[Z_WIDTH-1:0];
         acc_d = sum[Z_WIDTH-1:0];
         ovf_d = ovf | add_ovf;
      end else if (vld[0] && mode_acc && acc_clr) begin
         acc_d = p;
         ovf_d = 1'b0;
      end else if (acc_clr) begin
         // covers multiply-only with clear and a clear with no sample
         acc_d = '0;
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc <= '0;
         ovf <= 1'b0;
         for (int k = 1; k <= PIPE; k++) r_pipe[k] <= '0;
      end else begin
         acc <= acc_d;
         ovf <= ovf_d;
         // Stages load only behind a valid sample, so z holds between results.
         if (vld[0]) r_pipe[1] <= r;
         for (int k = 2; k <= PIPE; k++)
            if (vld[k-1]) r_pipe[k] <= r_pipe[k-1];
      end
   end

   assign z = r_pipe[PIPE];
endmodule

module sim_dsp_simd_mac #(
   parameter int LANES   = 2,
   parameter int A_WIDTH = 10,
   parameter int B_WIDTH = 9,
   parameter int Z_WIDTH = 19,
   parameter int PIPE    = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   sim_dsp_simd_mac_if.slave bus
);
   if (Z_WIDTH < A_WIDTH + B_WIDTH) begin : g_bad_z
      $error("sim_dsp_simd_mac: Z_WIDTH must be >= A_WIDTH+B_WIDTH");
   end
   if (PIPE < 1 || PIPE > 3) begin : g_bad_pipe
      $error("sim_dsp_simd_mac: PIPE must be 1..3");
   end
   if (LANES < 1) begin : g_bad_lanes
      $error("sim_dsp_simd_mac: LANES must be >= 1");
   end

   logic [PIPE:0] vld_pipe;

   assign vld_pipe[0] = bus.in_valid;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) vld_pipe[PIPE:1] <= '0;
      else          vld_pipe[PIPE:1] <= vld_pipe[PIPE-1:0];
   end

   assign bus.out_valid = vld_pipe[PIPE];

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      sim_dsp_simd_mac_lane #(
         .A_WIDTH (A_WIDTH),
         .B_WIDTH (B_WIDTH),
         .Z_WIDTH (Z_WIDTH),
         .PIPE    (PIPE)
      ) u_lane (
         .clk       (clk),
         .reset_n   (reset_n),
         .vld       (vld_pipe[PIPE-1:0]),
         .mode_acc  (bus.mode_acc),
         .signed_en (bus.signed_en),
         .acc_clr   (bus.acc_clr),
         .a         (bus.a[i*A_WIDTH +: A_WIDTH]),
         .b         (bus.b[i*B_WIDTH +: B_WIDTH]),
         .z         (bus.z[i*Z_WIDTH +: Z_WIDTH]),
         .ovf       (bus.ovf[i])
      );
   end
endmodule

// File: tb/tb_sim_dsp_simd_mac.sv
// tb_sim_dsp_simd_mac
//  Drives identical samples into a PIPE=1 and a PIPE=3 instance and checks
//  both against an arithmetic model every cycle, plus literal expectations.
`timescale 1ns/1ps
module tb_sim_dsp_simd_mac;
   localparam int L = 2, AW = 10, BW = 9, ZW = 19;
   localparam longint M    = (64'sd1 << ZW) - 1;
   localparam longint SMAX = (64'sd1 << (ZW-1)) - 1;
   localparam longint SMIN = -(64'sd1 << (ZW-1));

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic          in_valid = 0, mode_acc = 0, signed_en = 0, acc_clr = 0;
   logic [AW-1:0] av [L] = '{default: '0};
   logic [BW-1:0] bv [L] = '{default: '0};

   sim_dsp_simd_mac_if #(.LANES(L), .A_WIDTH(AW), .B_WIDTH(BW), .Z_WIDTH(ZW)) if0 ();
   sim_dsp_simd_mac_if #(.LANES(L), .A_WIDTH(AW), .B_WIDTH(BW), .Z_WIDTH(ZW)) if1 ();

   assign if0.in_valid = in_valid;  assign if1.in_valid = in_valid;
   assign if0.mode_acc = mode_acc;  assign if1.mode_acc = mode_acc;
   assign if0.signed_en = signed_en; assign if1.signed_en = signed_en;
   assign if0.acc_clr = acc_clr;    assign if1.acc_clr = acc_clr;
   assign if0.a = {av[1], av[0]};   assign if1.a = {av[1], av[0]};
   assign if0.b = {bv[1], bv[0]};   assign if1.b = {bv[1], bv[0]};

   sim_dsp_simd_mac #(.LANES(L), .A_WIDTH(AW), .B_WIDTH(BW), .Z_WIDTH(ZW), .PIPE(1))
      u_dut1 (.clk(clk), .reset_n(rst_n), .bus(if0));
   sim_dsp_simd_mac #(.LANES(L), .A_WIDTH(AW), .B_WIDTH(BW), .Z_WIDTH(ZW), .PIPE(3))
      u_dut3 (.clk(clk), .reset_n(rst_n), .bus(if1));

   int ntests = 0, nfail = 0;
   bit chk_en = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- model ----------------
   // Accumulator/overflow are shared (same stimulus); each instance gets its own delay line.
   longint m_acc [L];
   bit     m_ovf [L];
   bit     mv [2][3];
   longint mz [2][3][L];
   bit     ev [2];
   longint ez [2][L];
   longint rr [L];

   function automatic longint sx(input longint x);
      return (x > SMAX) ? x - (M + 1) : x;
   endfunction

   always @(posedge clk or negedge rst_n) begin : model
      if (!rst_n) begin
         for (int l = 0; l < L; l++) begin
            m_acc[l] = 0; m_ovf[l] = 0;
            for (int d = 0; d < 2; d++) begin
               ez[d][l] = 0;
               for (int k = 0; k < 3; k++) mz[d][k][l] = 0;
            end
         end
         for (int d = 0; d < 2; d++) begin
            ev[d] = 0;
            for (int k = 0; k < 3; k++) mv[d][k] = 0;
         end
      end else begin
         for (int l = 0; l < L; l++) begin
            longint x, y, p, s;
            x = signed_en ? longint'($signed(av[l])) : longint'(av[l]);
            y = signed_en ? longint'($signed(bv[l])) : longint'(bv[l]);
            p = (x * y) & M;
            rr[l] = p;
            if (in_valid && mode_acc && !acc_clr) begin
               if (signed_en) begin
                  s = sx(m_acc[l]) + sx(p);
                  if (s > SMAX || s < SMIN) m_ovf[l] = 1;
               end else begin
                  s = m_acc[l] + p;
                  if (s > M) m_ovf[l] = 1;
               end
               rr[l] = s & M;
               m_acc[l] = rr[l];
            end else if (in_valid && mode_acc) begin
               m_acc[l] = p; m_ovf[l] = 0;
            end else if (acc_clr) begin
               m_acc[l] = 0; m_ovf[l] = 0;
            end
         end
         for (int d = 0; d < 2; d++) begin
            int P;
            P = (d == 0) ? 1 : 3;
            for (int k = P-1; k >= 1; k--) begin
               mv[d][k] = mv[d][k-1];
               for (int l = 0; l < L; l++) mz[d][k][l] = mz[d][k-1][l];
            end
            mv[d][0] = in_valid;
            if (in_valid) for (int l = 0; l < L; l++) mz[d][0][l] = rr[l];
            ev[d] = mv[d][P-1];
            if (ev[d]) for (int l = 0; l < L; l++) ez[d][l] = mz[d][P-1][l];
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_en && rst_n) begin
         chk("p1_out_valid", 64'(if0.out_valid), 64'(ev[0]));
         chk("p1_z", 64'(if0.z), 64'({19'(ez[0][1]), 19'(ez[0][0])}));
         chk("p1_ovf", 64'(if0.ovf), 64'({m_ovf[1], m_ovf[0]}));
         chk("p3_out_valid", 64'(if1.out_valid), 64'(ev[1]));
         chk("p3_z", 64'(if1.z), 64'({19'(ez[1][1]), 19'(ez[1][0])}));
         chk("p3_ovf", 64'(if1.ovf), 64'({m_ovf[1], m_ovf[0]}));
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input bit v, input bit ma, input bit se, input bit cl,
                        input logic [AW-1:0] a0, input logic [BW-1:0] b0,
                        input logic [AW-1:0] a1, input logic [BW-1:0] b1);
      @(negedge clk); #1;
      in_valid = v; mode_acc = ma; signed_en = se; acc_clr = cl;
      av[0] = a0; bv[0] = b0; av[1] = a1; bv[1] = b1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 0, '0, '0, '0, '0);
   endtask

   task automatic after_edge();
      @(posedge clk); #1;
   endtask

   initial begin
      int cnt0, cnt1;
      #1 rst_n = 0;
      repeat (3) @(negedge clk);
      chk("rst_out_valid", 64'({if1.out_valid, if0.out_valid}), 64'd0);
      chk("rst_z", 64'(if0.z), 64'd0);
      chk("rst_ovf", 64'({if1.ovf, if0.ovf}), 64'd0);
      #1 rst_n = 1;
      chk_en = 1;
      idle(2);

      // 1: unsigned multiply
      drive(1, 0, 0, 0, 10'h3FF, 9'h1FF, 10'h002, 9'h003);
      after_edge();
      chk("t1_valid", 64'(if0.out_valid), 64'd1);
      chk("t1_z0", 64'(if0.z[18:0]), 64'h7FA01);
      chk("t1_z1", 64'(if0.z[37:19]), 64'h00006);
      idle(1);

      // 2: signed multiply
      drive(1, 0, 1, 0, 10'h3FF, 9'h1FF, 10'h200, 9'h0FF);
      after_edge();
      chk("t2_z0", 64'(if0.z[18:0]), 64'h00001);
      chk("t2_z1", 64'(if0.z[37:19]), 64'h60200);
      chk("t2_ovf", 64'(if0.ovf), 64'd0);
      idle(3);

      // 3: accumulate 3*5 four times, clear on first
      drive(1, 1, 0, 1, 10'd3, 9'd5, '0, '0); after_edge(); chk("t3_z0_a", 64'(if0.z[18:0]), 64'h0F);
      drive(1, 1, 0, 0, 10'd3, 9'd5, '0, '0); after_edge(); chk("t3_z0_b", 64'(if0.z[18:0]), 64'h1E);
      drive(1, 1, 0, 0, 10'd3, 9'd5, '0, '0); after_edge(); chk("t3_z0_c", 64'(if0.z[18:0]), 64'h2D);
      drive(1, 1, 0, 0, 10'd3, 9'd5, '0, '0); after_edge(); chk("t3_z0_d", 64'(if0.z[18:0]), 64'h3C);
      idle(3);

      // 4: unsigned accumulate overflow, sticky
      drive(1, 1, 0, 1, 10'h3FF, 9'h1FF, '0, '0); after_edge();
      chk("t4_z0_a", 64'(if0.z[18:0]), 64'h7FA01);
      chk("t4_ovf_a", 64'(if0.ovf), 64'd0);
      drive(1, 1, 0, 0, 10'h3FF, 9'h1FF, '0, '0); after_edge();
      chk("t4_z0_b", 64'(if0.z[18:0]), 64'h7F402);
      chk("t4_ovf_b", 64'(if0.ovf), 64'b01);
      idle(3);
      chk("t4_ovf_held", 64'(if0.ovf), 64'b01);
      // multiply-only samples leave ovf alone; a standalone clear drops it
      drive(0, 0, 0, 1, '0, '0, '0, '0); after_edge();
      chk("t4_ovf_clr", 64'(if0.ovf), 64'd0);

      // signed accumulate: lane0 positive overflow, lane1 negative without overflow
      drive(1, 1, 1, 1, 10'h1FF, 9'h0FF, 10'h3FF, 9'h002);
      drive(1, 1, 1, 0, 10'h1FF, 9'h0FF, 10'h3FF, 9'h002);
      drive(1, 1, 1, 0, 10'h1FF, 9'h0FF, 10'h3FF, 9'h002);
      after_edge();
      chk("sacc_ovf", 64'(if0.ovf), 64'b01);
      chk("sacc_z1", 64'(if0.z[37:19]), 64'h7FFFA);
      // load-mode clear with mixed mode changes, no bubble
      drive(1, 1, 0, 1, 10'd7, 9'd9, 10'd1, 9'd1);
      drive(1, 0, 1, 0, 10'h3FE, 9'd4, 10'd2, 9'd2);
      drive(1, 1, 0, 0, 10'd1, 9'd1, 10'd1, 9'd1);
      idle(4);

      // 5: PIPE=3 latency for a single pulse
      drive(1, 0, 0, 0, 10'd5, 9'd7, '0, '0);
      for (int k = 0; k < 6; k++) begin
         after_edge();
         if (k == 0) in_valid = 0;
         chk($sformatf("t5_valid_%0d", k), 64'(if1.out_valid), 64'(k == 2));
         if (k >= 2) chk($sformatf("t5_z0_%0d", k), 64'(if1.z[18:0]), 64'h23);
      end

      // 6: reset in the middle of a burst
      drive(1, 1, 0, 1, 10'd4, 9'd4, 10'd1, 9'd2);
      drive(1, 1, 0, 0, 10'd4, 9'd4, 10'd1, 9'd2);
      @(posedge clk); #2;
      rst_n = 0;
      #0.5;
      chk("t6_rst_valid", 64'({if1.out_valid, if0.out_valid}), 64'd0);
      chk("t6_rst_z", 64'({if1.z, if0.z}), 64'd0);
      chk("t6_rst_ovf", 64'({if1.ovf, if0.ovf}), 64'd0);
      #0.5 rst_n = 1;
      drive(1, 0, 0, 0, 10'd6, 9'd6, '0, '0);
      cnt0 = 0; cnt1 = 0;
      for (int k = 0; k < 6; k++) begin
         after_edge();
         if (k == 0) in_valid = 0;
         cnt0 += int'(if0.out_valid);
         cnt1 += int'(if1.out_valid);
      end
      chk("t6_cnt_p1", 64'(cnt0), 64'd1);
      chk("t6_cnt_p3", 64'(cnt1), 64'd1);
      chk("t6_z_p3", 64'(if1.z[18:0]), 64'h24);

      idle(2);
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end
endmodule
